// File: rtl/serial_adder_ctrl.sv
// serial_adder_ctrl: bit-serial adder, one bit per clock LSB first; `define SERIAL_ADDER_SUB_EN adds a sub port for a-b
module serial_adder_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub,
`endif
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sr, b_sr;
    logic [WIDTH-2:0] res_sr;
    logic [CNT_W-1:0] cnt;
    logic             carry, sub_r, sub_in;
    logic             last, b_bit, h_sum, s_bit, c_nxt;

`ifdef SERIAL_ADDER_SUB_EN
    assign sub_in = sub;
`else
    assign sub_in = 1'b0;
`endif

    always_comb begin
        last      = (cnt == LAST);
        b_bit     = b_sr[0] ^ sub_r;
        h_sum     = a_sr[0] ^ b_bit;
        s_bit     = h_sum ^ carry;
        c_nxt     = (a_sr[0] & b_bit) | (h_sum & carry);
        state_nxt = (state == IDLE) ? (start ? RUN : IDLE) :
                    (state == RUN)  ? (last ? DONE : RUN) : IDLE;
        busy      = (state == RUN);
        done      = (state == DONE);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // subtraction reuses the adder as a + ~b + 1, so the carry seeds with sub
    always_ff @(posedge clk) begin
        if (rst) begin
            a_sr   <= '0;
            b_sr   <= '0;
            res_sr <= '0;
            cnt    <= '0;
            carry  <= 1'b0;
            sub_r  <= 1'b0;
            sum    <= '0;
            cout   <= 1'b0;
        end else if (state == IDLE && start) begin
            a_sr  <= a;
            b_sr  <= b;
            sub_r <= sub_in;
            carry <= sub_in;
            cnt   <= '0;
        end else if (state == RUN) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            res_sr <= (WIDTH-1)'({s_bit, res_sr} >> 1);
            carry  <= c_nxt;
            cnt    <= cnt + 1'b1;
            if (last) begin
                sum  <= {s_bit, res_sr};
                cout <= c_nxt;
            end
        end
    end
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// tb_serial_adder_ctrl: directed vectors plus a per-cycle timeline/arithmetic model of serial_adder_ctrl
module tb_serial_adder_ctrl;
    localparam int WIDTH = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a = '0, b = '0;
    logic             sub = 1'b0;
    logic             busy, done, cout;
    logic [WIDTH-1:0] sum;

    serial_adder_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b),
`ifdef SERIAL_ADDER_SUB_EN
        .sub(sub),
`endif
        .busy(busy), .done(done), .sum(sum), .cout(cout)
    );

    always #5 clk = ~clk;

    int vectors = 0, miscompares = 0;
    int cyc = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // model: p=0 idle, 1..WIDTH operation in progress, WIDTH+1 completion cycle
    int               p = 0;
    logic [WIDTH-1:0] m_a = '0, m_b = '0, m_sum = '0;
    logic             m_sub = 1'b0, m_cout = 1'b0;
    logic [WIDTH:0]   m_full;

    always @(posedge clk) begin
        cyc++;
        if (rst) begin
            p = 0; m_sum = '0; m_cout = 1'b0;
        end else if (p == 0) begin
            if (start) begin
                p = 1; m_a = a; m_b = b;
`ifdef SERIAL_ADDER_SUB_EN
                m_sub = sub;
`endif
            end
        end else if (p == WIDTH) begin
            m_full = m_sub ? ({1'b0, m_a} + {1'b0, ~m_b} + 1) : ({1'b0, m_a} + {1'b0, m_b});
            m_sum  = m_full[WIDTH-1:0];
            m_cout = m_full[WIDTH];
            p = WIDTH + 1;
        end else if (p == WIDTH + 1) p = 0;
        else p++;
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("busy", busy, (p >= 1 && p <= WIDTH));
            chk("done", done, (p == WIDTH + 1));
            chk("sum", sum, m_sum);
            chk("cout", cout, m_cout);
        end
    end

    task automatic run_op(input logic [WIDTH-1:0] ia, ib, input logic isub,
                          input logic [WIDTH-1:0] esum, input logic ecout, input string name);
        int  n = 0;
        bit  got = 0;
        @(negedge clk);
        start = 1'b1; a = ia; b = ib; sub = isub;
        @(negedge clk);
        start = 1'b0; a = ~ia; b = ~ib;
        for (int i = 0; i < WIDTH + 4 && !got; i++) begin
            if (done) got = 1;
            else begin
                if (busy) n++;
                @(negedge clk);
            end
        end
        chk({name, "_timeout"}, got, 1);
        chk({name, "_busy_cycles"}, n, WIDTH);
        chk({name, "_sum"}, sum, esum);
        chk({name, "_cout"}, cout, ecout);
        @(negedge clk);
        chk({name, "_done_1cyc"}, done, 0);
    endtask

    initial begin
        int dn, t1, t2;
        logic [WIDTH-1:0] s1, s2;
        logic c1, c2;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk_en = 1'b1;
        chk("reset_sum", sum, 0);
        chk("reset_busy", busy, 0);

        run_op(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, "add_12_34");
        run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, "wrap_ff_01");
        run_op(8'hFF, 8'hFF, 1'b0, 8'hFE, 1'b1, "wrap_ff_ff");
        run_op(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, "add_a5_5a");

        // reset mid-operation
        @(negedge clk);
        start = 1'b1; a = 8'h0F; b = 8'h01;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_sum", sum, 8'h00);
        chk("rst_cout", cout, 0);
        dn = 0;
        repeat (12) begin @(negedge clk); if (done) dn++; end
        chk("rst_no_done", dn, 0);

        // start re-pulsed during RUN is ignored
        @(negedge clk);
        start = 1'b1; a = 8'h21; b = 8'h10;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        start = 1'b1; a = 8'hAA; b = 8'h55;
        @(negedge clk);
        start = 1'b0;
        dn = 0;
        repeat (14) begin @(negedge clk); if (done) dn++; end
        chk("ign_done_count", dn, 1);
        chk("ign_sum", sum, 8'h31);
        chk("ign_cout", cout, 0);

        // start held high: back-to-back operations
        @(negedge clk);
        start = 1'b1; a = 8'h80; b = 8'h80;
        @(negedge clk);
        a = 8'h01; b = 8'h02;
        t1 = -1; t2 = -1; s1 = '0; s2 = '0; c1 = 0; c2 = 0;
        for (int i = 0; i < 30 && t2 < 0; i++) begin
            @(negedge clk);
            if (done) begin
                if (t1 < 0) begin t1 = cyc; s1 = sum; c1 = cout; end
                else begin t2 = cyc; s2 = sum; c2 = cout; start = 1'b0; end
            end
        end
        start = 1'b0;
        chk("b2b_spacing", t2 - t1, WIDTH + 2);
        chk("b2b_sum1", s1, 8'h00);
        chk("b2b_cout1", c1, 1);
        chk("b2b_sum2", s2, 8'h03);
        chk("b2b_cout2", c2, 0);
        repeat (4) @(negedge clk);

`ifdef SERIAL_ADDER_SUB_EN
        run_op(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, "sub_05_07");
        run_op(8'h07, 8'h05, 1'b1, 8'h02, 1'b1, "sub_07_05");
        run_op(8'h07, 8'h05, 1'b0, 8'h0C, 1'b0, "sub0_07_05");
`endif

        repeat (3) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
